execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 92 +++++++++
 tb/tb_execute_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: single-cycle ALU plus a 32-iteration MULTU/DIVU unit
// that owns HI/LO and stalls the upstream stage while it works.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        DX_valid,
    input  logic [3:0]  DX_ALUctr,
    input  logic [31:0] DX_A,
    input  logic [31:0] DX_B,
    input  logic [31:0] DX_imm,
    input  logic        DX_ALUsrc,
    input  logic [4:0]  DX_RD,
    input  logic        DX_lwFlag,
    output logic [31:0] ALUout,
    output logic [4:0]  XM_RD,
    output logic        XM_lwFlag,
    output logic        XM_valid,
    output logic        X_stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
    md_state_t   state, state_nx;
    logic [31:0] hi, lo, md_a, md_hi, md_lo, op2, alu_res, nx_hi, nx_lo;
    logic [32:0] sum, sh;
    logic [4:0]  cnt;
    logic        is_div, is_md, md_start, ge;
    assign op2      = DX_ALUsrc ? DX_imm : DX_B;
    assign is_md    = DX_ALUctr == 4'b0011 || DX_ALUctr == 4'b0100;
    assign md_start = state == IDLE && DX_valid && is_md;
    assign X_stall  = rst && (md_start || state == BUSY);
    assign state_nx = state == IDLE ? (md_start ? BUSY : IDLE) :
                      state == BUSY ? (cnt == 5'd31 ? DONE : BUSY) : IDLE;
    // One shift-add (multiply) or restoring-subtract (divide) step.
    assign sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_a} : 33'd0);
    assign sh    = {md_hi, md_lo[31]};
    assign ge    = sh >= {1'b0, md_a};
    assign nx_hi = is_div ? (ge ? sh[31:0] - md_a : sh[31:0]) : sum[32:1];
    assign nx_lo = is_div ? {md_lo[30:0], ge} : {sum[0], md_lo[31:1]};
    always_comb begin
        alu_res = 32'd0;
        case (DX_ALUctr)
            4'b0000: alu_res = DX_A & op2;
            4'b0001: alu_res = DX_A | op2;
            4'b0010: alu_res = DX_A + op2;
            4'b0110: alu_res = DX_A - op2;
            4'b0111: alu_res = {31'd0, $signed(DX_A) < $signed(op2)};
            4'b1100: alu_res = ~(DX_A | op2);
            4'b1000: alu_res = DX_A << op2[4:0];
            4'b1010: alu_res = DX_A >> op2[4:0];
            4'b0101: alu_res = hi;
            4'b1001: alu_res = lo;
            default: alu_res = 32'd0;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hi        <= 32'd0;
            lo        <= 32'd0;
            md_a      <= 32'd0;
            md_hi     <= 32'd0;
            md_lo     <= 32'd0;
            is_div    <= 1'b0;
            cnt       <= 5'd0;
            ALUout    <= 32'd0;
            XM_RD     <= 5'd0;
            XM_lwFlag <= 1'b0;
            XM_valid  <= 1'b0;
        end else begin
            state <= state_nx;
            if (md_start) begin
                md_a   <= DX_B;
                md_hi  <= 32'd0;
                md_lo  <= DX_A;
                is_div <= DX_ALUctr == 4'b0100;
                cnt    <= 5'd0;
            end else if (state == BUSY) begin
                md_hi <= nx_hi;
                md_lo <= nx_lo;
                cnt   <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    hi <= nx_hi;
                    lo <= nx_lo;
                end
            end
            // DONE retires the held MULTU/DIVU as an empty writeback.
            XM_valid  <= state == DONE || (DX_valid && !X_stall);
            ALUout    <= (state != DONE && DX_valid && !X_stall) ? alu_res : 32'd0;
            XM_RD     <= (state != DONE && DX_valid && !X_stall) ? DX_RD : 5'd0;
            XM_lwFlag <= state != DONE && DX_valid && !X_stall && DX_lwFlag;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with a retire scoreboard checked by a
// separate monitor on the falling edge.
module tb_execute_stage;
    logic        clk = 0, rst = 0, DX_valid = 0, DX_ALUsrc = 0, DX_lwFlag = 0;
    logic [3:0]  DX_ALUctr = 0;
    logic [31:0] DX_A = 0, DX_B = 0, DX_imm = 0;
    logic [4:0]  DX_RD = 0;
    logic [31:0] ALUout;
    logic [4:0]  XM_RD;
    logic        XM_lwFlag, XM_valid, X_stall;
    logic [37:0] sb[$];
    int          checks = 0, errors = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .DX_valid(DX_valid), .DX_ALUctr(DX_ALUctr),
        .DX_A(DX_A), .DX_B(DX_B), .DX_imm(DX_imm), .DX_ALUsrc(DX_ALUsrc),
        .DX_RD(DX_RD), .DX_lwFlag(DX_lwFlag), .ALUout(ALUout), .XM_RD(XM_RD),
        .XM_lwFlag(XM_lwFlag), .XM_valid(XM_valid), .X_stall(X_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (XM_valid) begin
                    if (sb.size() == 0) chk("unexpected_retire", {XM_RD, ALUout}, 64'd0);
                    else begin
                        e = sb.pop_front();
                        chk("retire_alu", ALUout, e[37:6]);
                        chk("retire_rd", XM_RD, e[5:1]);
                        chk("retire_lw", XM_lwFlag, e[0]);
                    end
                end else chk("bubble_zero", {XM_lwFlag, XM_RD, ALUout}, 64'd0);
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src, input logic [4:0] rd,
                        input logic lw, input logic [31:0] res);
        bit md;
        bit s;
        int st;
        md = c == 4'b0011 || c == 4'b0100;
        st = 0;
        DX_valid = 1; DX_ALUctr = c; DX_A = a; DX_B = b; DX_imm = imm;
        DX_ALUsrc = src; DX_RD = rd; DX_lwFlag = lw;
        sb.push_back(md ? 38'd0 : {res, rd, lw});
        do begin
            #1 s = X_stall;
            @(posedge clk);
            @(negedge clk);
            if (s) st++;
        end while (s && st <= 100);
        chk("stall_cycles", st, md ? 33 : 0);
        DX_valid = 0;
    endtask

    initial begin
        DX_valid = 1; DX_ALUctr = 4'b0011; DX_A = 7; DX_B = 9;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", X_stall, 0);
        chk("reset_outs", {XM_valid, XM_lwFlag, XM_RD, ALUout}, 0);
        DX_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        send(4'b0010, 32'h7FFFFFFF, 1, 0, 0, 5, 0, 32'h80000000);
        send(4'b0111, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 1);
        send(4'b0111, 1, 32'hFFFFFFFF, 0, 0, 2, 0, 0);
        send(4'b0110, 0, 1, 0, 0, 3, 0, 32'hFFFFFFFF);
        send(4'b0010, 32'h10, 0, 32'hFFFFFFFC, 1, 8, 1, 32'hC);
        send(4'b0000, 32'hF0F0, 32'hFF00, 0, 0, 4, 0, 32'hF000);
        send(4'b0001, 32'hF0F0, 32'hFF00, 0, 0, 6, 0, 32'hFFF0);
        send(4'b1100, 0, 0, 0, 0, 7, 0, 32'hFFFFFFFF);
        send(4'b1000, 1, 0, 32'h23, 1, 9, 0, 8);
        send(4'b1010, 32'h80000000, 31, 0, 0, 10, 0, 1);
        send(4'b1111, 32'h1234, 32'h5678, 0, 0, 11, 0, 0);
        send(4'b0011, 32'hFFFFFFFF, 2, 0, 0, 12, 0, 0);
        send(4'b0101, 0, 0, 0, 0, 13, 0, 1);
        send(4'b1001, 0, 0, 0, 0, 14, 0, 32'hFFFFFFFE);
        send(4'b0100, 100, 7, 0, 0, 15, 0, 0);
        send(4'b1001, 0, 0, 0, 0, 16, 0, 14);
        send(4'b0101, 0, 0, 0, 0, 17, 0, 2);
        send(4'b0100, 5, 0, 0, 0, 18, 0, 0);
        send(4'b0101, 0, 0, 0, 0, 19, 0, 5);
        send(4'b1001, 0, 0, 0, 0, 20, 0, 32'hFFFFFFFF);
        // Abort a MULTU at iteration 10, then let the held op restart.
        DX_valid = 1; DX_ALUctr = 4'b0011; DX_A = 3; DX_B = 5; DX_RD = 0;
        repeat (11) @(negedge clk);
        chk("busy_stall", X_stall, 1);
        #1 rst = 0;
        #1;
        chk("abort_stall", X_stall, 0);
        chk("abort_outs", {XM_valid, XM_lwFlag, XM_RD, ALUout}, 0);
        @(negedge clk);
        rst = 1;
        send(4'b0011, 3, 5, 0, 0, 0, 0, 0);
        send(4'b1001, 0, 0, 0, 0, 21, 0, 15);
        send(4'b0101, 0, 0, 0, 0, 22, 0, 0);
        // Abort a DIVU and confirm HI/LO were cleared.
        DX_valid = 1; DX_ALUctr = 4'b0100; DX_A = 100; DX_B = 7;
        repeat (6) @(negedge clk);
        #1 rst = 0;
        DX_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        send(4'b1001, 0, 0, 0, 0, 23, 0, 0);
        send(4'b0101, 0, 0, 0, 0, 24, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
